// File: rtl/clock_time_setter.sv
// Drives timekeeper add_minute/add_hour pulses until the reported
// time matches a latched target, then reports done or error.
module clock_time_setter #(
   parameter int SETTLE    = 1,
   parameter int MAX_STEPS = 120
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       abort,
   input  logic       AM_mode,
   input  logic [5:0] target_hr,
   input  logic [5:0] target_min,
   input  logic       target_pm,
   input  logic [5:0] curr_hr,
   input  logic [5:0] curr_min,
   input  logic       curr_AM_PM,
   output logic       add_minute,
   output logic       add_hour,
   output logic       busy,
   output logic       done,
   output logic       error
);

   localparam int CB = $clog2(MAX_STEPS + 1);
   localparam int CW = (CB > 7) ? CB : 7;
   localparam logic [CW-1:0] MAX_C = CW'(MAX_STEPS);
   localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);

   typedef enum logic [2:0] {
      IDLE, CHECK, PULSE_MIN, PULSE_HR, WAIT, DONE
   } state_t;

   state_t        state_q, state_d;
   logic [5:0]    tgt_hr_q, tgt_hr_d;
   logic [5:0]    tgt_min_q, tgt_min_d;
   logic          tgt_pm_q, tgt_pm_d;
   logic          mode_q, mode_d;
   logic [CW-1:0] step_q, step_d;
   logic [3:0]    wait_q, wait_d;
   logic          add_minute_q, add_minute_d;
   logic          add_hour_q, add_hour_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          error_q, error_d;

   logic tgt_ok;
   logic min_miss;
   logic hr_miss;

   always_comb begin
      tgt_ok = (target_min <= 6'd59) &&
               (AM_mode ? (target_hr != 6'd0 && target_hr <= 6'd12)
                        : (target_hr <= 6'd23));
      min_miss = (curr_min != tgt_min_q);
      hr_miss  = (curr_hr != tgt_hr_q) ||
                 (mode_q && (curr_AM_PM != tgt_pm_q));
   end

   always_comb begin
      state_d      = state_q;
      tgt_hr_d     = tgt_hr_q;
      tgt_min_d    = tgt_min_q;
      tgt_pm_d     = tgt_pm_q;
      mode_d       = mode_q;
      step_d       = step_q;
      wait_d       = wait_q;
      add_minute_d = 1'b0;
      add_hour_d   = 1'b0;
      busy_d       = busy_q;
      done_d       = 1'b0;
      error_d      = 1'b0;
      if (state_q == IDLE) begin
         if (start) begin
            if (!tgt_ok) begin
               error_d = 1'b1;
            end else begin
               tgt_hr_d  = target_hr;
               tgt_min_d = target_min;
               tgt_pm_d  = target_pm;
               mode_d    = AM_mode;
               step_d    = '0;
               busy_d    = 1'b1;
               state_d   = CHECK;
            end
         end
      end else if (abort) begin
         busy_d  = 1'b0;
         state_d = IDLE;
      end else if (AM_mode != mode_q) begin
         error_d = 1'b1;
         busy_d  = 1'b0;
         state_d = IDLE;
      end else begin
         unique case (state_q)
            CHECK: begin
               if (min_miss || hr_miss) begin
                  if (step_q >= MAX_C) begin
                     error_d = 1'b1;
                     busy_d  = 1'b0;
                     state_d = IDLE;
                  end else if (min_miss) begin
                     add_minute_d = 1'b1;
                     state_d      = PULSE_MIN;
                  end else begin
                     add_hour_d = 1'b1;
                     state_d    = PULSE_HR;
                  end
               end else begin
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
                  state_d = DONE;
               end
            end
            PULSE_MIN, PULSE_HR: begin
               step_d  = (&step_q) ? step_q : step_q + 1'b1;
               wait_d  = '0;
               state_d = WAIT;
            end
            WAIT: begin
               if (wait_q == SETTLE_M1) begin
                  state_d = CHECK;
               end else begin
                  wait_d = wait_q + 1'b1;
               end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         tgt_hr_q     <= '0;
         tgt_min_q    <= '0;
         tgt_pm_q     <= 1'b0;
         mode_q       <= 1'b0;
         step_q       <= '0;
         wait_q       <= '0;
         add_minute_q <= 1'b0;
         add_hour_q   <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         tgt_hr_q     <= tgt_hr_d;
         tgt_min_q    <= tgt_min_d;
         tgt_pm_q     <= tgt_pm_d;
         mode_q       <= mode_d;
         step_q       <= step_d;
         wait_q       <= wait_d;
         add_minute_q <= add_minute_d;
         add_hour_q   <= add_hour_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         error_q      <= error_d;
      end
   end

   assign add_minute = add_minute_q;
   assign add_hour   = add_hour_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign error      = error_q;

endmodule

// File: tb/tb_clock_time_setter.sv
// Directed bench for clock_time_setter with a behavioural timekeeper
// responder per DUT instance (default and MAX_STEPS=4).
module tb_clock_time_setter;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start [2];
   logic       abort = 1'b0;
   logic       AM_mode = 1'b0;
   logic [5:0] target_hr = '0;
   logic [5:0] target_min = '0;
   logic       target_pm = 1'b0;
   logic [5:0] chr [2];
   logic [5:0] cmin [2];
   logic       cpm [2];
   logic       add_min [2];
   logic       add_hr [2];
   logic       busy [2];
   logic       done [2];
   logic       error [2];
   logic       ld [2];
   logic [5:0] ld_hr = '0;
   logic [5:0] ld_min = '0;
   logic       ld_pm = 1'b0;

   int n_chk = 0;
   int n_err = 0;
   int done_cyc, err_cyc, p1, p2, nmin, nhr;
   int busy1, busy_end, busy_act, both;

   always #5 clk = ~clk;

   clock_time_setter u_dut0 (
      .clk(clk), .reset(reset), .start(start[0]), .abort(abort),
      .AM_mode(AM_mode), .target_hr(target_hr),
      .target_min(target_min), .target_pm(target_pm),
      .curr_hr(chr[0]), .curr_min(cmin[0]), .curr_AM_PM(cpm[0]),
      .add_minute(add_min[0]), .add_hour(add_hr[0]),
      .busy(busy[0]), .done(done[0]), .error(error[0])
   );

   clock_time_setter #(.SETTLE(1), .MAX_STEPS(4)) u_dut1 (
      .clk(clk), .reset(reset), .start(start[1]), .abort(abort),
      .AM_mode(AM_mode), .target_hr(target_hr),
      .target_min(target_min), .target_pm(target_pm),
      .curr_hr(chr[1]), .curr_min(cmin[1]), .curr_AM_PM(cpm[1]),
      .add_minute(add_min[1]), .add_hour(add_hr[1]),
      .busy(busy[1]), .done(done[1]), .error(error[1])
   );

   function automatic logic [6:0] inc_hr(logic [5:0] h, logic p,
                                         logic m12);
      if (m12) begin
         if (h == 6'd11) return {~p, 6'd12};
         if (h == 6'd12) return {p, 6'd1};
         return {p, h + 6'd1};
      end
      if (h == 6'd23) return {p, 6'd0};
      return {p, h + 6'd1};
   endfunction

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (ld[i]) begin
            chr[i]  <= ld_hr;
            cmin[i] <= ld_min;
            cpm[i]  <= ld_pm;
         end else if (add_min[i]) begin
            if (cmin[i] == 6'd59) begin
               cmin[i] <= 6'd0;
               {cpm[i], chr[i]} <= inc_hr(chr[i], cpm[i], AM_mode);
            end else begin
               cmin[i] <= cmin[i] + 6'd1;
            end
         end else if (add_hr[i]) begin
            {cpm[i], chr[i]} <= inc_hr(chr[i], cpm[i], AM_mode);
         end
      end
   end

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic set_time(input int d, input logic [5:0] h,
                           input logic [5:0] m, input logic p);
      @(negedge clk);
      ld_hr = h; ld_min = m; ld_pm = p; ld[d] = 1'b1;
      @(negedge clk);
      ld[d] = 1'b0;
   endtask

   task automatic set_tgt(input logic mode, input logic [5:0] h,
                          input logic [5:0] m, input logic p);
      AM_mode = mode; target_hr = h; target_min = m; target_pm = p;
   endtask

   // act_cyc: cycle at which abort (act_mode=0) or mode toggle is driven
   task automatic run_op(input int d, input int budget,
                         input int act_cyc, input bit act_mode);
      done_cyc = -1; err_cyc = -1; p1 = -1; p2 = -1;
      nmin = 0; nhr = 0; busy1 = 0; busy_end = -1;
      busy_act = -1; both = 0;
      @(negedge clk);
      start[d] = 1'b1;
      @(posedge clk);
      for (int c = 1; c <= budget; c++) begin
         @(negedge clk);
         start[d] = 1'b0;
         abort = 1'b0;
         if (c == 1) busy1 = int'(busy[d]);
         if (c == act_cyc + 1) busy_act = int'(busy[d]);
         if (add_min[d]) begin
            nmin++;
            if (p1 < 0) p1 = c;
            else if (p2 < 0) p2 = c;
         end
         if (add_hr[d]) nhr++;
         if (add_min[d] && add_hr[d]) both = 1;
         if (done[d] && done_cyc < 0) done_cyc = c;
         if (error[d] && err_cyc < 0) err_cyc = c;
         if (c == act_cyc) begin
            if (act_mode) AM_mode = ~AM_mode;
            else abort = 1'b1;
         end
         if (done_cyc >= 0 || err_cyc >= 0) begin
            busy_end = int'(busy[d]);
            break;
         end
      end
   endtask

   initial begin
      start[0] = 1'b0; start[1] = 1'b0;
      ld[0] = 1'b0; ld[1] = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_add_min", int'(add_min[0]), 0);
      chk("rst_add_hr", int'(add_hr[0]), 0);
      chk("rst_busy", int'(busy[0]), 0);
      chk("rst_done", int'(done[0]), 0);
      chk("rst_error", int'(error[1]), 0);
      reset = 1'b0;

      // 24h 10:58 -> 11:00
      set_time(0, 6'd10, 6'd58, 1'b0);
      set_tgt(1'b0, 6'd11, 6'd0, 1'b0);
      run_op(0, 30, -5, 1'b0);
      chk("t1_busy_c1", busy1, 1);
      chk("t1_pulse1", p1, 2);
      chk("t1_pulse2", p2, 5);
      chk("t1_nmin", nmin, 2);
      chk("t1_nhr", nhr, 0);
      chk("t1_done_cyc", done_cyc, 8);
      chk("t1_busy_done", busy_end, 0);
      chk("t1_hr", int'(chr[0]), 11);
      chk("t1_min", int'(cmin[0]), 0);

      // 12h 11:30 AM -> 12:30 PM
      set_time(0, 6'd11, 6'd30, 1'b0);
      set_tgt(1'b1, 6'd12, 6'd30, 1'b1);
      run_op(0, 30, -5, 1'b0);
      chk("t2_nhr", nhr, 1);
      chk("t2_nmin", nmin, 0);
      chk("t2_done_cyc", done_cyc, 5);
      chk("t2_pm", int'(cpm[0]), 1);
      chk("t2_hr", int'(chr[0]), 12);
      chk("t2_both", both, 0);

      // invalid 12h hour 0
      set_tgt(1'b1, 6'd0, 6'd10, 1'b0);
      run_op(0, 10, -5, 1'b0);
      chk("t3_err_cyc", err_cyc, 1);
      chk("t3_busy", busy1, 0);
      chk("t3_pulses", nmin + nhr, 0);

      // invalid minute 60
      set_tgt(1'b0, 6'd5, 6'd60, 1'b0);
      run_op(0, 10, -5, 1'b0);
      chk("t3b_err_cyc", err_cyc, 1);

      // already equal 07:15
      set_time(0, 6'd7, 6'd15, 1'b0);
      set_tgt(1'b0, 6'd7, 6'd15, 1'b0);
      run_op(0, 10, -5, 1'b0);
      chk("t4_done_cyc", done_cyc, 2);
      chk("t4_pulses", nmin + nhr, 0);

      // timeout with MAX_STEPS=4
      set_time(1, 6'd0, 6'd0, 1'b0);
      set_tgt(1'b0, 6'd0, 6'd10, 1'b0);
      run_op(1, 40, -5, 1'b0);
      chk("t5_nmin", nmin, 4);
      chk("t5_err_cyc", err_cyc, 14);
      chk("t5_done", done_cyc, -1);
      chk("t5_busy_end", busy_end, 0);
      chk("t5_min", int'(cmin[1]), 4);

      // abort in WAIT after second pulse
      set_time(0, 6'd10, 6'd0, 1'b0);
      set_tgt(1'b0, 6'd10, 6'd5, 1'b0);
      run_op(0, 20, 6, 1'b0);
      chk("t6_nmin", nmin, 2);
      chk("t6_busy_next", busy_act, 0);
      chk("t6_done", done_cyc, -1);
      chk("t6_err", err_cyc, -1);

      // AM_mode toggled in WAIT after second pulse
      set_time(0, 6'd10, 6'd0, 1'b0);
      set_tgt(1'b0, 6'd10, 6'd5, 1'b0);
      run_op(0, 20, 6, 1'b1);
      chk("t7_err_cyc", err_cyc, 7);
      chk("t7_nmin", nmin, 2);
      chk("t7_busy", busy_act, 0);
      AM_mode = 1'b0;

      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors",
               n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/clock_time_setter.md
# clock_time_setter

Autonomous time-setting initiator for the clock timekeeper. It accepts a target time and drives the timekeeper's `add_minute` / `add_hour` single-cycle increment inputs until the timekeeper's reported `hr` / `min` / `AM_PM` equal the target. It then reports completion or an error. It sits beside the timekeeper in the top-level clock and replaces manual button pressing for the set operation: the timekeeper is the responder, this block is the initiator.

## Interface
Parameters:
- `SETTLE`, default 1: idle cycles after each increment pulse before the next compare (range 1..15).
- `MAX_STEPS`, default 120: maximum increment pulses per operation before a timeout error.

Ports:
- `clk` — in, 1 — system clock; the clock and the timekeeper share it.
- `reset` — in, 1 — reset is synchronous and active-high; one clock; no other clock domain.
- `start` — in, 1 — request pulse; sampled only in IDLE.
- `abort` — in, 1 — cancel the operation; honoured in any non-IDLE state.
- `AM_mode` — in, 1 — 1 = 12-hour mode, 0 = 24-hour mode.
- `target_hr` — in, 6 — 1..12 when `AM_mode`=1; 0..23 when `AM_mode`=0.
- `target_min` — in, 6 — 0..59.
- `target_pm` — in, 1 — PM flag; used only when `AM_mode`=1.
- `curr_hr`, `curr_min` — in, 6 each — timekeeper outputs.
- `curr_AM_PM` — in, 1 — timekeeper output.
- `add_minute`, `add_hour` — out, 1 each — registered increment pulses to the timekeeper.
- `busy` — out, 1 — high from the cycle after an accepted `start` until the cycle of `done`, `error` or abort.
- `done` — out, 1 — one-cycle pulse: target reached.
- `error` — out, 1 — one-cycle pulse: invalid target, timeout, or mode change.

## Operation
- States: IDLE, CHECK, PULSE_MIN, PULSE_HR, WAIT, DONE.
- **IDLE, on `start`:**
  - Invalid target: `error`=1 next cycle; no pulses; stay in IDLE. Invalid means `target_min`>59; in 12-hour mode, `target_hr` of 0 or >12; in 24-hour mode, `target_hr`>23.
  - Valid target: latch `target_*` and `AM_mode`; clear the step counter; go to CHECK.
- **CHECK:** priority order, evaluated in one cycle.
  - Minute mismatch (`curr_min`≠target) → PULSE_MIN.
  - Else hour mismatch → PULSE_HR. In 12-hour mode this means `hr` or `AM_PM` differ from target; in 24-hour mode it compares `hr` only.
  - Else → DONE.
  - Minutes are stepped first because a 59→0 minute wrap carries into the hour. Any mismatch re-found after hours are stepped (a carry, or an autonomous tick) loops back through CHECK.
- **PULSE_MIN / PULSE_HR:** the matching output is high for exactly this cycle; the step counter increments; go to WAIT.
- **WAIT:** hold for `SETTLE` cycles, then go to CHECK.
- **Timeout:** on entry to CHECK with the step counter = `MAX_STEPS` and a mismatch present: `error` pulse, return to IDLE, no further pulses.
- **DONE:** `done`=1 for one cycle; `busy` low in the same cycle; go to IDLE.
- **Mode change:** if `AM_mode` differs from the latched value in any non-IDLE state: `error` pulse, go to IDLE, and suppress any pulse not yet issued.
- **`abort`:** the next state is IDLE; `busy` drops next cycle; no `done`/`error` pulse. A pulse already registered in the current cycle still completes.
- **Mutual exclusion:** `add_minute` and `add_hour` are never high in the same cycle. Neither is ever high in IDLE, CHECK, WAIT or DONE.
- **`start` while busy:** ignored. **`start` with `abort` in IDLE:** `abort` has no effect and `start` is processed.
- **Step counter:** 7 bits minimum (wide enough for `MAX_STEPS`) and saturating.
- Target already equal at `start`: CHECK → DONE with zero pulses.

## Timing
- Reset values: all outputs 0, state IDLE, step counter 0, latched targets 0.
- Operation timing, with `start` accepted in cycle 0:
  - CHECK is in cycle 1.
  - The first pulse is in cycle 2.
  - The timekeeper registers the increment at the end of cycle 2.
  - The next CHECK is in cycle 3+`SETTLE`.
- Per-step period is `SETTLE`+2 cycles: 3 cycles with default settings.
- Zero-step completion: `done` in cycle 2.
- Latency from the final matching CHECK to `done` is 1 cycle.
- Reset asserted mid-operation: outputs go to 0 on the next edge; no `done`/`error` pulse.

## Test plan
- 24-hour mode, curr 10:58, target 11:00. The bench responder applies only the pulses, with no autonomous ticks. Required: `add_minute` high in cycles 2 and 5; `add_hour` never high; `done` in cycle 8; final 11:00.
- 12-hour mode, curr 11:30 AM, target 12:30 PM. Required: exactly one `add_hour` (11 AM→12 PM); `done` with `curr_AM_PM`=1.
- Invalid target (12-hour mode, `target_hr`=0). Required: `error` in cycle 1; `busy` stays 0; no pulses.
- `start` with the target equal to current (07:15). Required: `done` in cycle 2; zero pulses.
- `MAX_STEPS`=4, curr min 0, target min 10. Required: exactly 4 `add_minute` pulses, then `error`; `busy` low afterwards.
- Abort in WAIT after the second pulse; a separate run toggles `AM_mode` in WAIT. Required for abort: no further pulses, `busy` low next cycle, no `done`. Required for the mode toggle: `error` pulse.
